// File: rtl/signal_measure_pkg.sv
// Shared types and defaults for the square-wave period / high-time measurement unit.
package signal_measure_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int unsigned TIMEOUT_DEF = 50_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_e;

  localparam logic [1:0] S_IDLE      = 2'(IDLE);
  localparam logic [1:0] S_ARM       = 2'(ARM);
  localparam logic [1:0] S_MEAS_HIGH = 2'(MEAS_HIGH);
  localparam logic [1:0] S_MEAS_LOW  = 2'(MEAS_LOW);

endpackage

// File: rtl/signal_measure_sync.sv
// 2-FF synchronizer plus one delay flop; yields the clean level and single-cycle edge strobes.
module sync_edge_detect
  import signal_measure_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
    end else begin
      meta <= din;
      s    <= meta;
      s_d  <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/signal_measure.sv
// One-shot period / high-time measurement of an asynchronous square wave, in clk cycles.
// start is accepted only in IDLE; busy is high whenever the FSM is outside IDLE.
module signal_measure
  import signal_measure_pkg::*;
#(
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic [1:0]       state,
  output logic             sync_level
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             rise;
  logic             fall;
  logic [1:0]       state_q;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] tmo_cnt;

  sync_edge_detect u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (signal_in),
    .s     (sync_level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      period_cnt    <= '0;
      high_cnt      <= '0;
      tmo_cnt       <= '0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      period_cycles <= '0;
      high_cycles   <= '0;
    end else begin
      done <= 1'b0;
      if (state_q == S_IDLE) begin
        tmo_cnt <= '0;
        if (start) begin
          state_q <= S_ARM;
          timeout <= 1'b0;
        end
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
        // Timeout is checked first so it beats a coincident rise.
        if (tmo_cnt == TMO_LAST) begin
          state_q       <= S_IDLE;
          done          <= 1'b1;
          timeout       <= 1'b1;
          period_cycles <= '0;
          high_cycles   <= '0;
        end else begin
          case (state_q)
            S_ARM: begin
              if (rise) begin
                period_cnt <= CNT_W'(1);
                high_cnt   <= CNT_W'(1);
                state_q    <= S_MEAS_HIGH;
              end
            end
            S_MEAS_HIGH: begin
              period_cnt <= period_cnt + 1'b1;
              if (fall) begin
                state_q <= S_MEAS_LOW;
              end else begin
                high_cnt <= high_cnt + 1'b1;
              end
            end
            S_MEAS_LOW: begin
              if (rise) begin
                period_cycles <= period_cnt;
                high_cycles   <= high_cnt;
                done          <= 1'b1;
                state_q       <= S_IDLE;
              end else begin
                period_cnt <= period_cnt + 1'b1;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign state = state_q;

endmodule
